// File: rtl/pfb_synth_pkg.sv
// rtl/pfb_synth_pkg.sv - shared types and sizing helpers for the PFB synthesis framer
package pfb_synth_pkg;

    localparam int CPLX_B = 16;

    typedef struct packed {
        logic signed [CPLX_B-1:0] q;
        logic signed [CPLX_B-1:0] i;
    } cplx_t;

    typedef enum logic {HUNT, LOCK} state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int nb(input int n, input int l);
        return n / (2 * l);
    endfunction

endpackage

// File: rtl/pfb_skid_buf.sv
// rtl/pfb_skid_buf.sv - 2-entry stream register slice; s_ready is a pure register output
module pfb_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    logic [W-1:0] skid_data;
    logic         skid_full;

    assign s_ready = !skid_full;

    // The skid entry only fills while the output register is stalled, so it always holds the younger beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data    <= '0;
            m_valid   <= 1'b0;
            skid_data <= '0;
            skid_full <= 1'b0;
        end else if (!m_valid || m_ready) begin
            if (skid_full) begin
                m_data    <= skid_data;
                m_valid   <= 1'b1;
                skid_full <= 1'b0;
            end else begin
                m_valid <= s_valid;
                if (s_valid) begin
                    m_data <= s_data;
                end
            end
        end else if (s_valid && !skid_full) begin
            skid_data <= s_data;
            skid_full <= 1'b1;
        end
    end

endmodule

// File: rtl/pfb_synth_framer.sv
// rtl/pfb_synth_framer.sv - frame lock, tlast regeneration and misalignment count; PFB_FRAMER_ZEROFILL_EN emits zero beats while hunting
module pfb_synth_framer
    import pfb_synth_pkg::*;
#(
    parameter int N = 64,
    parameter int L = 4,
    parameter int B = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [2*L*2*B-1:0]   s_axis_tdata,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [2*L*2*B-1:0]   m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 LOCKED,
    output logic [15:0]          ERR_CNT
);

    localparam int DW = 2 * L * 2 * B;
    localparam int NB = nb(N, L);
    localparam int CW = clog2_min1(NB);
    localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [15:0]   err_cnt, err_n;
    logic          accept, emit, beat_last;
    logic [DW-1:0] fwd_data;

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign beat_last = (cnt == CNT_LAST);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= HUNT;
            cnt     <= '0;
            err_cnt <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            err_cnt <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        err_n    = err_cnt;
        emit     = 1'b0;
        fwd_data = s_axis_tdata;
        case (state)
            HUNT: begin
`ifdef PFB_FRAMER_ZEROFILL_EN
                emit     = 1'b1;
                fwd_data = '0;
                if (accept) begin
                    cnt_n = beat_last ? '0 : cnt + CW'(1);
                end
`endif
                if (accept && s_axis_tlast) begin
                    state_n = LOCK;
                    cnt_n   = '0;
                end
            end
            LOCK: begin
                emit = 1'b1;
                if (accept) begin
                    cnt_n = beat_last ? '0 : cnt + CW'(1);
                    if (s_axis_tlast != beat_last) begin
                        if (err_cnt != 16'hFFFF) begin
                            err_n = err_cnt + 16'd1;
                        end
                        // A premature marker is still a boundary: restart the frame instead of re-hunting.
                        if (s_axis_tlast) begin
                            cnt_n = '0;
                        end else begin
                            state_n = HUNT;
                        end
                    end
                end
            end
            default: state_n = HUNT;
        endcase
    end

    pfb_skid_buf #(.W(DW + 1)) u_skid (
        .clk     (aclk),
        .rst     (areset),
        .s_data  ({beat_last, fwd_data}),
        .s_valid (s_axis_tvalid && emit),
        .s_ready (s_axis_tready),
        .m_data  ({m_axis_tlast, m_axis_tdata}),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

    assign LOCKED  = (state == LOCK);
    assign ERR_CNT = err_cnt;

endmodule

// File: tb/tb_pfb_synth_framer.sv
// tb/tb_pfb_synth_framer.sv - randomized scoreboard bench for pfb_synth_framer
module tb_pfb_synth_framer;
    import pfb_synth_pkg::*;

    localparam int N  = 64;
    localparam int L  = 4;
    localparam int B  = 16;
    localparam int DW = 2 * L * 2 * B;
    localparam int NB = N / (2 * L);

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic          aclk = 1'b0;
    logic          areset;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          LOCKED;
    logic [15:0]   ERR_CNT;

    pfb_synth_framer #(.N(N), .L(L), .B(B)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .LOCKED        (LOCKED),
        .ERR_CNT       (ERR_CNT)
    );

    always #5 aclk = ~aclk;

    int    n_chk  = 0;
    int    n_fail = 0;
    int    n_pop  = 0;
    int    bp_mode  = 0;
    int    bp_phase = 0;
    bit    prev_stall = 0;
    beat_t prev_beat;

    // Reference: expected in-flight beats, frame position and lock flag
    beat_t exp_q[$];
    bit    m_locked = 0;
    int    m_pos = 0;
    int    m_err = 0;

    function automatic void model_reset();
        exp_q.delete();
        m_locked = 0;
        m_pos    = 0;
        m_err    = 0;
    endfunction

    function automatic void model_push(input logic [DW-1:0] data, input logic last);
        bit eof;
        if (!m_locked) begin
`ifdef PFB_FRAMER_ZEROFILL_EN
            exp_q.push_back('{last: (m_pos == NB - 1), data: '0});
            m_pos = (m_pos + 1) % NB;
`endif
            if (last) begin
                m_locked = 1;
                m_pos    = 0;
            end
        end else begin
            eof = (m_pos == NB - 1);
            exp_q.push_back('{last: eof, data: data});
            m_pos = (m_pos + 1) % NB;
            if (last != eof) begin
                if (m_err < 65535) m_err++;
                m_pos = 0;
                if (!last) m_locked = 0;
            end
        end
    endfunction

    function automatic logic [DW-1:0] make_beat(input int b);
        logic [DW-1:0] d;
        cplx_t c;
        for (int k = 0; k < 2 * L; k++) begin
            c.q = 16'(k);
            c.i = 16'(b);
            d[k*32 +: 32] = c;
        end
        return d;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic cycle(output bit acc);
        bit pop;
        case (bp_mode)
            1:       m_axis_tready = (bp_phase % 4 == 0) || (bp_phase % 4 == 3);
            2:       m_axis_tready = ($urandom % 4) != 0;
            default: m_axis_tready = 1'b1;
        endcase
        bp_phase++;
        #3;
        n_chk++;
        if (s_axis_tready !== (exp_q.size() < 2)) begin
            n_fail++;
            $display("FAIL s_tready: got %b want %b", s_axis_tready, exp_q.size() < 2);
        end
        n_chk++;
        if (m_axis_tvalid !== (exp_q.size() > 0)) begin
            n_fail++;
            $display("FAIL m_tvalid: got %b want %b", m_axis_tvalid, exp_q.size() > 0);
        end
        if (prev_stall) begin
            n_chk++;
            if ({m_axis_tlast, m_axis_tdata} !== prev_beat) begin
                n_fail++;
                $display("FAIL stall_stable: got %h want %h", {m_axis_tlast, m_axis_tdata}, prev_beat);
            end
        end
        acc = s_axis_tvalid && s_axis_tready;
        pop = m_axis_tvalid && m_axis_tready;
        if (pop && exp_q.size() > 0) begin
            n_chk++;
            if ({m_axis_tlast, m_axis_tdata} !== exp_q[0]) begin
                n_fail++;
                $display("FAIL out_beat: got last=%b %h want last=%b %h",
                         m_axis_tlast, m_axis_tdata, exp_q[0].last, exp_q[0].data);
            end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = {m_axis_tlast, m_axis_tdata};
        @(posedge aclk);
        #1;
        if (pop && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            n_pop++;
        end
        if (acc) model_push(s_axis_tdata, s_axis_tlast);
        n_chk++;
        if (LOCKED !== m_locked) begin
            n_fail++;
            $display("FAIL locked: got %b want %b", LOCKED, m_locked);
        end
        n_chk++;
        if (ERR_CNT !== 16'(m_err)) begin
            n_fail++;
            $display("FAIL err_cnt: got %0d want %0d", ERR_CNT, m_err);
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] data, input logic last);
        bit acc = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = data;
        s_axis_tlast  = last;
        for (int i = 0; i < 20 && !acc; i++) cycle(acc);
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: got no accept want accept within 20 cycles");
        end
    endtask

    task automatic drain();
        bit acc;
        s_axis_tvalid = 1'b0;
        bp_mode = 0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(acc);
        cycle(acc);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d beats pending want 0", exp_q.size());
        end
    endtask

    task automatic send_frame(input int base, input bit mark);
        for (int b = 0; b < NB; b++) send_beat(make_beat(base + b), mark && (b == NB - 1));
    endtask

    task automatic apply_reset();
        areset = 1'b1;
        model_reset();
        prev_stall = 0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    task automatic test_reset();
        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        n_chk++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_m_ctrl: got valid=%b last=%b want 0 0", m_axis_tvalid, m_axis_tlast);
        end
        n_chk++;
        if (m_axis_tdata !== '0) begin
            n_fail++;
            $display("FAIL reset_m_data: got %h want 0", m_axis_tdata);
        end
        n_chk++;
        if (s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_s_tready: got %b want 1", s_axis_tready);
        end
        n_chk++;
        if (LOCKED !== 1'b0 || ERR_CNT !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_status: got locked=%b err=%0d want 0 0", LOCKED, ERR_CNT);
        end
        areset = 1'b0;
    endtask

    task automatic test_lock_frames();
        int want_pop;
        n_pop = 0;
        bp_mode = 0;
        send_frame(0, 1);
        n_chk++;
        if (LOCKED !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_after_marker: got %b want 1", LOCKED);
        end
        send_frame(8, 1);
        send_frame(16, 1);
        drain();
`ifdef PFB_FRAMER_ZEROFILL_EN
        want_pop = 24;
`else
        want_pop = 16;
`endif
        n_chk++;
        if (n_pop != want_pop) begin
            n_fail++;
            $display("FAIL lock_beat_count: got %0d want %0d", n_pop, want_pop);
        end
    endtask

    task automatic test_early_tlast();
        for (int b = 0; b < 5; b++) send_beat(make_beat(100 + b), b == 4);
        n_chk++;
        if (ERR_CNT !== 16'd1 || LOCKED !== 1'b1) begin
            n_fail++;
            $display("FAIL early_tlast: got err=%0d locked=%b want 1 1", ERR_CNT, LOCKED);
        end
        send_frame(200, 1);
        drain();
        n_chk++;
        if (ERR_CNT !== 16'd1) begin
            n_fail++;
            $display("FAIL early_realign: got err=%0d want 1", ERR_CNT);
        end
    endtask

    task automatic test_missing_tlast();
        send_frame(300, 0);
        n_chk++;
        if (ERR_CNT !== 16'd2 || LOCKED !== 1'b0) begin
            n_fail++;
            $display("FAIL missing_tlast: got err=%0d locked=%b want 2 0", ERR_CNT, LOCKED);
        end
        for (int b = 0; b < 3; b++) send_beat(make_beat(400 + b), 1'b0);
        send_beat(make_beat(403), 1'b1);
        n_chk++;
        if (LOCKED !== 1'b1) begin
            n_fail++;
            $display("FAIL relock: got %b want 1", LOCKED);
        end
        drain();
    endtask

    task automatic test_backpressure();
        bp_mode  = 1;
        bp_phase = 0;
        send_frame(500, 1);
        bp_mode = 1;
        send_frame(508, 1);
        drain();
    endtask

    task automatic test_random();
        bit acc;
        int sp = 0;
        bp_mode = 2;
        for (int i = 0; i < 600; i++) begin
            s_axis_tvalid = ($urandom % 10) < 7;
            s_axis_tdata  = rand_beat();
            s_axis_tlast  = (sp == NB - 1) ^ (($urandom % 16) == 0);
            cycle(acc);
            if (acc) sp = (sp + 1) % NB;
        end
        drain();
    endtask

    task automatic test_reset_mid();
        bp_mode = 1;
        send_beat(make_beat(600), 1'b1);
        for (int b = 0; b < 3; b++) send_beat(make_beat(601 + b), 1'b0);
        #2;
        areset = 1'b1;
        #1;
        n_chk++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_out: got valid=%b last=%b data=%h want 0", m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        n_chk++;
        if (s_axis_tready !== 1'b1 || LOCKED !== 1'b0 || ERR_CNT !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reset_status: got rdy=%b locked=%b err=%0d want 1 0 0", s_axis_tready, LOCKED, ERR_CNT);
        end
        model_reset();
        prev_stall = 0;
        s_axis_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    task automatic test_hunt_fill();
        int want_pop;
        apply_reset();
        n_pop = 0;
        bp_mode = 0;
        for (int b = 0; b < 10; b++) send_beat(make_beat(700 + b), 1'b0);
        send_beat(make_beat(710), 1'b1);
        send_frame(720, 1);
        drain();
`ifdef PFB_FRAMER_ZEROFILL_EN
        want_pop = 19;
`else
        want_pop = 8;
`endif
        n_chk++;
        if (n_pop != want_pop) begin
            n_fail++;
            $display("FAIL hunt_beat_count: got %0d want %0d", n_pop, want_pop);
        end
    endtask

    initial begin
        test_reset();
        test_lock_frames();
        test_early_tlast();
        test_missing_tlast();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_hunt_fill();
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
